dac_scheduler: RTL and testbench

Round-robin scheduler that shares the single SPI DAC core (four-channel, 12-bit) between four independent requesters, e.g. game audio and level outputs. Each requester posts a 12-bit value on its channel with a req/ack handshake. The scheduler owns the core's `enable`, `data` and `address` inputs and serialises one transfer at a time. It treats the core's one-cycle `done` pulse as completion, and a watchdog recovers from a core that never finishes.

---
 rtl/dac_scheduler.sv | 174 +++++++++++++++++
 tb/tb_dac_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_scheduler.sv
// Round-robin arbiter sharing one four-channel 12-bit SPI DAC core between
// four req/ack requesters. One transfer at a time: IDLE -> LOAD -> XFER -> GAP.
// A watchdog aborts a transfer whose core never reports done.
module dac_scheduler #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [47:0] req_data,
    output logic [3:0]  ack,
    output logic [3:0]  grant,
    output logic        timeout,
    output logic        busy,
    output logic        dac_enable,
    output logic [11:0] dac_data,
    output logic [3:0]  dac_address,
    input  logic        dac_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [15:0] CNT_MAX_C = 16'hFFFF;

    // Pick the 12-bit value belonging to channel idx.
    function automatic logic [11:0] slice_sel(input logic [47:0] data, input logic [1:0] idx);
        logic [11:0] s;
        case (idx)
            2'd0:    s = data[11:0];
            2'd1:    s = data[23:12];
            2'd2:    s = data[35:24];
            2'd3:    s = data[47:36];
            default: s = 12'h000;
        endcase
        return s;
    endfunction

    state_t      state_r, state_next_s;
    logic [1:0]  last_r, last_next_s;
    logic [15:0] cnt_r, cnt_next_s;
    logic [3:0]  ack_r, ack_next_s;
    logic [3:0]  grant_r, grant_next_s;
    logic        timeout_r, timeout_next_s;
    logic        busy_r, busy_next_s;
    logic        enable_r, enable_next_s;
    logic [11:0] data_r, data_next_s;
    logic [3:0]  address_r, address_next_s;

    logic        win_found_s;
    logic [1:0]  win_idx_s;
    logic [1:0]  cand_s;

    // Round-robin search: start one past the last winner and take the first pending channel.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 2'd0;
        cand_s      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand_s = last_r + 2'(k + 1);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic; ack/timeout are single-cycle pulses by default.
    always_comb begin
        state_next_s   = state_r;
        last_next_s    = last_r;
        cnt_next_s     = cnt_r;
        ack_next_s     = 4'b0000;
        grant_next_s   = grant_r;
        timeout_next_s = 1'b0;
        busy_next_s    = busy_r;
        enable_next_s  = enable_r;
        data_next_s    = data_r;
        address_next_s = address_r;

        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    data_next_s    = slice_sel(req_data, win_idx_s);
                    address_next_s = {2'b00, win_idx_s};
                    grant_next_s   = 4'b0001 << win_idx_s;
                    last_next_s    = win_idx_s;
                    busy_next_s    = 1'b1;
                    state_next_s   = LOAD;
                end else begin
                    busy_next_s    = 1'b0;
                    enable_next_s  = 1'b0;
                end
            end
            LOAD: begin
                enable_next_s = 1'b1;
                cnt_next_s    = 16'd0;
                state_next_s  = XFER;
            end
            XFER: begin
                // done takes priority over a watchdog expiry in the same cycle
                if (dac_done) begin
                    ack_next_s    = grant_r;
                    enable_next_s = 1'b0;
                    state_next_s  = GAP;
                end else if (cnt_r == TIMEOUT_C) begin
                    timeout_next_s = 1'b1;
                    enable_next_s  = 1'b0;
                    state_next_s   = GAP;
                end else if (cnt_r != CNT_MAX_C) begin
                    cnt_next_s = cnt_r + 16'd1;
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            GAP: begin
                // enable stays low this cycle so the core returns to its initial state
                enable_next_s = 1'b0;
                grant_next_s  = 4'b0000;
                busy_next_s   = 1'b0;
                state_next_s  = IDLE;
            end
            default: begin
                enable_next_s = 1'b0;
                grant_next_s  = 4'b0000;
                busy_next_s   = 1'b0;
                state_next_s  = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; last=3 makes channel 0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            last_r    <= 2'd3;
            cnt_r     <= 16'd0;
            ack_r     <= 4'b0000;
            grant_r   <= 4'b0000;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
            enable_r  <= 1'b0;
            data_r    <= 12'h000;
            address_r <= 4'h0;
        end else begin
            state_r   <= state_next_s;
            last_r    <= last_next_s;
            cnt_r     <= cnt_next_s;
            ack_r     <= ack_next_s;
            grant_r   <= grant_next_s;
            timeout_r <= timeout_next_s;
            busy_r    <= busy_next_s;
            enable_r  <= enable_next_s;
            data_r    <= data_next_s;
            address_r <= address_next_s;
        end
    end

    assign ack         = ack_r;
    assign grant       = grant_r;
    assign timeout     = timeout_r;
    assign busy        = busy_r;
    assign dac_enable  = enable_r;
    assign dac_data    = data_r;
    assign dac_address = address_r;

endmodule

// File: tb/tb_dac_scheduler.sv
// Directed bench for dac_scheduler: table of complete transfers plus
// hand-written watchdog, abandon, spurious-done and reset sequences.
module tb_dac_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [47:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        timeout;
    logic        busy;
    logic        dac_enable;
    logic [11:0] dac_data;
    logic [3:0]  dac_address;
    logic        dac_done;

    int n_checks = 0;
    int n_errors = 0;

    dac_scheduler #(.TIMEOUT(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .grant       (grant),
        .timeout     (timeout),
        .busy        (busy),
        .dac_enable  (dac_enable),
        .dac_data    (dac_data),
        .dac_address (dac_address),
        .dac_done    (dac_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic [3:0]  req;
        logic [47:0] data;
        int          delay;
        logic [3:0]  exp_grant;
        logic [3:0]  exp_addr;
        logic [11:0] exp_data;
        logic [3:0]  req_after;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        req      = 4'b0000;
        dac_done = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_grant", 48'(grant), 48'h0);
        check("rst_ack", 48'(ack), 48'h0);
        check("rst_timeout", 48'(timeout), 48'h0);
        check("rst_busy", 48'(busy), 48'h0);
        check("rst_enable", 48'(dac_enable), 48'h0);
        check("rst_data", 48'(dac_data), 48'h0);
        check("rst_addr", 48'(dac_address), 48'h0);
    endtask

    // Assumes FSM in IDLE and req already driven; finishes with FSM back in IDLE.
    task automatic run_xfer(input logic [3:0] eg, input logic [3:0] ea, input logic [11:0] ed,
                            input int delay, input logic [3:0] req_after);
        int bad;
        tick();
        check("grant", 48'(grant), 48'(eg));
        check("address", 48'(dac_address), 48'(ea));
        check("data", 48'(dac_data), 48'(ed));
        check("busy_load", 48'(busy), 48'h1);
        check("enable_load", 48'(dac_enable), 48'h0);
        tick();
        check("enable_rise", 48'(dac_enable), 48'h1);
        bad = 0;
        for (int i = 0; i < delay; i++) begin
            tick();
            if (grant !== eg || dac_data !== ed || dac_enable !== 1'b1 || ack !== 4'b0000)
                bad++;
        end
        check("xfer_stable", 48'(bad), 48'h0);
        dac_done = 1'b1;
        tick();
        dac_done = 1'b0;
        check("ack", 48'(ack), 48'(eg));
        check("enable_gap", 48'(dac_enable), 48'h0);
        check("no_timeout", 48'(timeout), 48'h0);
        req = req_after;
        tick();
        check("ack_pulse_end", 48'(ack), 48'h0);
        check("grant_clear", 48'(grant), 48'h0);
        check("enable_idle", 48'(dac_enable), 48'h0);
        check("busy_idle", 48'(busy), 48'h0);
    endtask

    initial begin
        int n;
        int bad;
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = 48'h0;
        dac_done = 1'b0;

        vecs[0] = '{1'b1, 4'b0100, {12'h000, 12'hABC, 12'h000, 12'h000}, 70, 4'b0100, 4'h2, 12'hABC, 4'b0000};
        vecs[1] = '{1'b1, 4'b1111, {12'h444, 12'h333, 12'h222, 12'h111}, 70, 4'b0001, 4'h0, 12'h111, 4'b1111};
        vecs[2] = '{1'b0, 4'b1111, {12'h444, 12'h333, 12'h222, 12'h111}, 5,  4'b0010, 4'h1, 12'h222, 4'b1111};
        vecs[3] = '{1'b0, 4'b1111, {12'h444, 12'h333, 12'h222, 12'h111}, 1,  4'b0100, 4'h2, 12'h333, 4'b1111};
        vecs[4] = '{1'b0, 4'b1111, {12'h444, 12'h333, 12'h222, 12'h111}, 0,  4'b1000, 4'h3, 12'h444, 4'b1111};
        vecs[5] = '{1'b0, 4'b1111, {12'h444, 12'h333, 12'h222, 12'h111}, 3,  4'b0001, 4'h0, 12'h111, 4'b0000};
        vecs[6] = '{1'b0, 4'b1010, {12'hC33, 12'hC22, 12'hC11, 12'hC00}, 2,  4'b0010, 4'h1, 12'hC11, 4'b1010};
        vecs[7] = '{1'b0, 4'b1010, {12'hC33, 12'hC22, 12'hC11, 12'hC00}, 2,  4'b1000, 4'h3, 12'hC33, 4'b1010};
        vecs[8] = '{1'b0, 4'b0110, {12'hC33, 12'hC22, 12'hC11, 12'hC00}, 2,  4'b0010, 4'h1, 12'hC11, 4'b0000};

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].do_rst)
                apply_reset();
            req_data = vecs[v].data;
            req      = vecs[v].req;
            run_xfer(vecs[v].exp_grant, vecs[v].exp_addr, vecs[v].exp_data,
                     vecs[v].delay, vecs[v].req_after);
        end

        // Watchdog: done never arrives
        apply_reset();
        req_data = {12'h000, 12'h000, 12'h000, 12'h7E7};
        req      = 4'b0001;
        tick();
        check("wd_grant", 48'(grant), 48'h1);
        tick();
        check("wd_enable_rise", 48'(dac_enable), 48'h1);
        n = 0;
        bad = 0;
        while (timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (ack !== 4'b0000)
                bad++;
        end
        check("wd_latency", 48'(n), 48'd101);
        check("wd_no_ack", 48'(bad), 48'h0);
        check("wd_ack_at_timeout", 48'(ack), 48'h0);
        check("wd_enable_low", 48'(dac_enable), 48'h0);
        tick();
        check("wd_timeout_pulse", 48'(timeout), 48'h0);
        check("wd_grant_clear", 48'(grant), 48'h0);
        tick();
        check("wd_regrant", 48'(grant), 48'h1);
        check("wd_regrant_data", 48'(dac_data), 48'h7E7);
        tick();
        check("wd2_enable_rise", 48'(dac_enable), 48'h1);
        // done coincides with watchdog expiry: done must win
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (timeout !== 1'b0 || dac_enable !== 1'b1)
                bad++;
        end
        check("wd2_stable", 48'(bad), 48'h0);
        dac_done = 1'b1;
        tick();
        dac_done = 1'b0;
        check("tie_ack", 48'(ack), 48'h1);
        check("tie_no_timeout", 48'(timeout), 48'h0);
        req = 4'b0000;
        tick();
        check("tie_idle", 48'(grant), 48'h0);

        // Abandon and late data: req drops and data changes mid-XFER
        req_data = {12'h000, 12'h000, 12'h5A5, 12'h000};
        req      = 4'b0010;
        tick();
        check("ab_grant", 48'(grant), 48'h2);
        tick();
        tick();
        tick();
        req      = 4'b0000;
        req_data = 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < 5; i++)
            tick();
        check("ab_data_held", 48'(dac_data), 48'h5A5);
        check("ab_grant_held", 48'(grant), 48'h2);
        check("ab_addr_held", 48'(dac_address), 48'h1);
        dac_done = 1'b1;
        tick();
        dac_done = 1'b0;
        check("ab_ack", 48'(ack), 48'h2);
        tick();
        tick();
        check("ab_no_regrant", 48'(grant), 48'h0);
        check("ab_not_busy", 48'(busy), 48'h0);

        // Spurious done in IDLE
        dac_done = 1'b1;
        tick();
        dac_done = 1'b0;
        check("sp_no_ack", 48'(ack), 48'h0);
        tick();
        check("sp_no_ack2", 48'(ack), 48'h0);
        check("sp_not_busy", 48'(busy), 48'h0);

        // Reset mid-XFER, then channel 0 wins first
        req_data = {12'h999, 12'h000, 12'h000, 12'h123};
        req      = 4'b1001;
        tick();
        check("rx_grant_ch3", 48'(grant), 48'h8);
        tick();
        tick();
        tick();
        check("rx_in_xfer", 48'(dac_enable), 48'h1);
        rst = 1'b1;
        tick();
        check("rx_enable", 48'(dac_enable), 48'h0);
        check("rx_grant", 48'(grant), 48'h0);
        check("rx_busy", 48'(busy), 48'h0);
        check("rx_data", 48'(dac_data), 48'h0);
        rst = 1'b0;
        tick();
        check("rx_first_ch0", 48'(grant), 48'h1);
        check("rx_first_data", 48'(dac_data), 48'h123);
        tick();
        dac_done = 1'b1;
        tick();
        dac_done = 1'b0;
        check("rx_ack", 48'(ack), 48'h1);
        req = 4'b0000;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
